// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with run/stop control and a one-deep
// pending-divisor slot that takes effect on the next falling edge of o_clk.
module clk_div_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_div_valid,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_div_ready,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             accept;
    logic             bound;
    logic             fall;

    assign o_div_ready = !pend_vld_q;
    assign accept      = i_div_valid && o_div_ready;
    assign bound       = (cnt_q == act_q - ONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        fall       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = ZERO;
                clk_d = 1'b0;
                if (i_en) state_d = RUN;
            end
            RUN, STOPPING: begin
                if (!i_en && !clk_q) begin
                    state_d = IDLE;
                    cnt_d   = ZERO;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d  = bound ? ZERO : cnt_q + ONE;
                    clk_d  = clk_q ^ bound;
                    tick_d = bound && !clk_q;
                    fall   = bound && clk_q;
                    // Low phase after the stop request is never started
                    if (i_en)      state_d = RUN;
                    else if (fall) state_d = IDLE;
                    else           state_d = STOPPING;
                end
            end
            default: state_d = IDLE;
        endcase

        // pend_vld_q is registered, so a divisor accepted on a falling
        // boundary waits for the following one.
        if (pend_vld_q && (fall || state_q == IDLE)) begin
            act_d      = pend_q;
            cnt_d      = ZERO;
            pend_vld_d = 1'b0;
        end

        if (accept) begin
            if (i_div == ZERO) begin
                err_d = 1'b1;
            end else if (state_q == IDLE) begin
                act_d = i_div;
            end else begin
                pend_d     = i_div;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= ZERO;
            act_q      <= CNT_W'(DEF_DIV);
            pend_q     <= ZERO;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_tick = tick_q;
    assign o_err  = err_q;
    assign o_busy = (state_q != IDLE);

endmodule
